// File: rtl/host_seq_if.sv
// host_seq_if: host/array handshake bundle for host_seq.
// Parameters: HC_W (host_controller word width), EX_W (ex_bus result width).
// Signals:
//   cfg_valid/cfg_ready/cfg_data        config word push from the host.
//   start                               launches a sequence.
//   done_i/ex_bus_i                     array completion flag and result bus.
//   init/run/host_controller            command stream to the array.
//   res_valid/res_ready/res_data        result return handshake.
//   busy                                sequencer not idle.
//   timeout                             sticky run timeout (HOST_SEQ_TIMEOUT_EN only).
// Modports: master = host/array side, slave = host_seq.
interface host_seq_if #(
   parameter int HC_W = 32,
   parameter int EX_W = 64
);
   logic            cfg_valid;
   logic            cfg_ready;
   logic [HC_W-1:0] cfg_data;
   logic            start;
   logic            done_i;
   logic [EX_W-1:0] ex_bus_i;
   logic            init;
   logic            run;
   logic [HC_W-1:0] host_controller;
   logic            res_valid;
   logic            res_ready;
   logic [EX_W-1:0] res_data;
   logic            busy;
`ifdef HOST_SEQ_TIMEOUT_EN
   logic            timeout;
`endif
   modport master (
      output cfg_valid, cfg_data, start, done_i, ex_bus_i, res_ready,
      input  cfg_ready, init, run, host_controller, res_valid, res_data, busy
`ifdef HOST_SEQ_TIMEOUT_EN
      , timeout
`endif
   );
   modport slave (
      input  cfg_valid, cfg_data, start, done_i, ex_bus_i, res_ready,
      output cfg_ready, init, run, host_controller, res_valid, res_data, busy
`ifdef HOST_SEQ_TIMEOUT_EN
      , timeout
`endif
   );
endinterface

// File: rtl/host_seq.sv
// host_seq: host command sequencer driving init/config-load/run phases of the array and returning its result.
// Optional feature macro: HOST_SEQ_TIMEOUT_EN adds a run-phase cycle limit and the sticky timeout flag.
// Ports:
//   clk  single clock, rising edge.
//   rst  synchronous active-high reset.
//   bus  host_seq_if.slave: config FIFO push, start, array done/result, init/run/host_controller
//        stream, result valid/ready handshake, busy (and timeout when enabled).
module host_seq #(
   parameter int HC_W       = 32,
   parameter int EX_W       = 64,
   parameter int FIFO_DEPTH = 8,
   parameter int INIT_CYC   = 4,
   parameter int TIMEOUT    = 4096
) (
   input logic      clk,
   input logic      rst,
   host_seq_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(INIT_CYC + 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || INIT_CYC < 1 || TIMEOUT < 1) begin : g_bad_param
      $error("host_seq: illegal parameter set");
   end

   typedef enum logic [2:0] {IDLE, INIT, LOAD, RUN, DONE} state_t;

   state_t          state;
   logic [HC_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [CW-1:0]   count;
   logic [IW-1:0]   icnt;
   logic            push, pop, empty, load_step;
   logic            init_r, run_r, res_valid_r, busy_r;
   logic [HC_W-1:0] hc_r;
   logic [EX_W-1:0] res_data_r;
`ifdef HOST_SEQ_TIMEOUT_EN
   localparam int RW = $clog2(TIMEOUT + 1);
   logic [RW-1:0]   rcnt;
   logic            timeout_r;
   assign bus.timeout = timeout_r;
`endif

   assign empty         = count == '0;
   assign bus.cfg_ready = count != CW'(FIFO_DEPTH);
   assign push          = bus.cfg_valid && bus.cfg_ready;
   // The last INIT cycle already pops, so the first word lands right after init drops.
   assign load_step     = state == LOAD || (state == INIT && icnt == '0);
   assign pop           = load_step && !empty;

   assign bus.init            = init_r;
   assign bus.run             = run_r;
   assign bus.host_controller = hc_r;
   assign bus.res_valid       = res_valid_r;
   assign bus.res_data        = res_data_r;
   assign bus.busy            = busy_r;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= bus.cfg_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         icnt        <= '0;
         init_r      <= 1'b0;
         run_r       <= 1'b0;
         hc_r        <= '0;
         res_valid_r <= 1'b0;
         res_data_r  <= '0;
         busy_r      <= 1'b0;
`ifdef HOST_SEQ_TIMEOUT_EN
         rcnt        <= '0;
         timeout_r   <= 1'b0;
`endif
      end else begin
         hc_r <= pop ? mem[rptr] : '0;
         case (state)
            IDLE: if (bus.start) begin
               state  <= INIT;
               icnt   <= IW'(INIT_CYC - 1);
               init_r <= 1'b1;
               busy_r <= 1'b1;
`ifdef HOST_SEQ_TIMEOUT_EN
               rcnt   <= '0;
`endif
            end
            INIT: if (icnt != '0) icnt <= icnt - 1'b1;
            else begin
               init_r <= 1'b0;
               state  <= empty ? RUN : LOAD;
               run_r  <= empty;
            end
            LOAD: if (empty) begin
               state <= RUN;
               run_r <= 1'b1;
            end
            RUN: if (bus.done_i) begin
               run_r       <= 1'b0;
               res_valid_r <= 1'b1;
               res_data_r  <= bus.ex_bus_i;
               state       <= DONE;
            end
`ifdef HOST_SEQ_TIMEOUT_EN
            else if (rcnt == RW'(TIMEOUT - 1)) begin
               run_r       <= 1'b0;
               timeout_r   <= 1'b1;
               res_valid_r <= 1'b1;
               res_data_r  <= '0;
               state       <= DONE;
            end else rcnt <= rcnt + 1'b1;
`endif
            DONE: if (bus.res_ready) begin
               res_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
